// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: HD44780-style LCD bus cycle generator with programmable setup/pulse/hold/gap
// timing and optional 4-bit (two-nibble) transfers.
module lcd_bus_cycle #(
  parameter int TAS_CYC = 2,
  parameter int TPW_CYC = 12,
  parameter int TH_CYC = 2,
  parameter int TGAP_CYC = 25,
  parameter int NIBBLE_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
);
  localparam int M1 = TAS_CYC > TPW_CYC ? TAS_CYC : TPW_CYC;
  localparam int M2 = TH_CYC > TGAP_CYC ? TH_CYC : TGAP_CYC;
  localparam int MAXP = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MAXP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic nib, rw_r;
  logic [7:0] din_r, rd_buf;
  logic cnt0, fin, more;
  assign cnt0 = cnt == '0;
  // fin marks the last clock of a transfer; GAP is bypassed entirely when TGAP_CYC is 0
  assign fin = cnt0 && (state == GAP || (state == HOLD && TGAP_CYC == 0));
  assign more = NIBBLE_MODE != 0 && !nib;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      nib <= 1'b0;
      rw_r <= 1'b0;
      din_r <= 8'h00;
      rd_buf <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
      dout <= 8'h00;
      lcd_e <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      lcd_db_out <= 8'h00;
      lcd_db_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!cnt0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= SETUP;
          cnt <= CW'(TAS_CYC - 1);
          busy <= 1'b1;
          nib <= 1'b0;
          rw_r <= rw_in;
          din_r <= din;
          lcd_rs <= rs_in;
          lcd_rw <= rw_in;
          lcd_db_oe <= ~rw_in;
          lcd_db_out <= rw_in ? 8'h00 : NIBBLE_MODE != 0 ? {din[7:4], 4'h0} : din;
        end
        SETUP: if (cnt0) begin
          state <= EHIGH;
          cnt <= CW'(TPW_CYC - 1);
          lcd_e <= 1'b1;
        end
        EHIGH: if (cnt0) begin
          state <= HOLD;
          cnt <= CW'(TH_CYC - 1);
          lcd_e <= 1'b0;
          if (NIBBLE_MODE == 0) rd_buf <= lcd_db_in;
          else if (nib) rd_buf[3:0] <= lcd_db_in[7:4];
          else rd_buf[7:4] <= lcd_db_in[7:4];
        end
        HOLD: if (cnt0 && TGAP_CYC != 0) begin
          state <= GAP;
          cnt <= CW'(TGAP_CYC - 1);
          lcd_db_oe <= 1'b0;
        end
        GAP: ;
        default: state <= IDLE;
      endcase
      // end of a transfer overrides the per-state update: next nibble or completion
      if (fin) begin
        if (more) begin
          state <= SETUP;
          cnt <= CW'(TAS_CYC - 1);
          nib <= 1'b1;
          lcd_db_oe <= ~rw_r;
          lcd_db_out <= rw_r ? 8'h00 : {din_r[3:0], 4'h0};
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          lcd_rs <= 1'b0;
          lcd_rw <= 1'b0;
          lcd_db_oe <= 1'b0;
          lcd_db_out <= 8'h00;
          if (rw_r) dout <= rd_buf;
        end
      end
    end
  end
endmodule
